// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: serialises MIPS fetch (IF) and data (DM) accesses onto one shared memory port.
// Ports:
//    clk_i, rst_ni                   clock (rising edge), asynchronous active-low reset
//    if_req_i/if_addr_i              fetch request; if_rdata_o/if_ack_o return the word
//    dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i  data request; dm_rdata_o/dm_ack_o return load data
//    mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  registered memory strobe, held until mem_ready_i
//    mem_rdata_i/mem_ready_i         memory response
//    mem_timeout_o                   one-cycle pulse when an access is aborted
module mips_mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int MAX_DM_STREAK = 4,
   parameter int TIMEOUT = 64,
   parameter logic [DW-1:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic [DW-1:0] if_rdata_o,
   output logic          if_ack_o,
   input  logic          dm_req_i,
   input  logic          dm_we_i,
   input  logic [AW-1:0] dm_addr_i,
   input  logic [DW-1:0] dm_wdata_i,
   output logic [DW-1:0] dm_rdata_o,
   output logic          dm_ack_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic          mem_ready_i,
   output logic          mem_timeout_o
);
   localparam int SW = $clog2(MAX_DM_STREAK + 1);
   localparam int TW = $clog2(TIMEOUT);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
   state_e state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic dm_gnt_q, dm_gnt_d, req_q, req_d, we_q, we_d, tout_q, tout_d, dm_win;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   // DM keeps priority until it has starved a waiting fetch MAX_DM_STREAK times in a row
   assign dm_win = dm_req_i && !(if_req_i && streak_q == SW'(MAX_DM_STREAK));
   always_comb begin
      state_d = state_q;
      streak_d = streak_q;
      tcnt_d = tcnt_q;
      dm_gnt_d = dm_gnt_q;
      req_d = req_q;
      we_d = we_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      tout_d = 1'b0;
      case (state_q)
         IDLE: if (dm_req_i || if_req_i) begin
            state_d = BUSY;
            req_d = 1'b1;
            dm_gnt_d = dm_win;
            addr_d = dm_win ? dm_addr_i : if_addr_i;
            we_d = dm_win && dm_we_i;
            wdata_d = dm_win ? dm_wdata_i : '0;
            // a DM win with if_req set implies streak < MAX, so +1 cannot overshoot
            streak_d = (dm_win && if_req_i) ? streak_q + 1'b1 : '0;
         end
         BUSY: begin
            tcnt_d = tcnt_q + 1'b1;
            if (mem_ready_i || tcnt_q == TW'(TIMEOUT - 1)) begin
               state_d = RESP;
               req_d = 1'b0;
               we_d = 1'b0;
               tout_d = !mem_ready_i;
               if (!we_q) begin
                  if_rdata_d = (!dm_gnt_q) ? (mem_ready_i ? mem_rdata_i : ERR_DATA) : if_rdata_q;
                  dm_rdata_d = dm_gnt_q ? (mem_ready_i ? mem_rdata_i : ERR_DATA) : dm_rdata_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tcnt_d = '0;
         end
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         streak_q <= '0;
         tcnt_q <= '0;
         dm_gnt_q <= 1'b0;
         req_q <= 1'b0;
         we_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         tout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         streak_q <= streak_d;
         tcnt_q <= tcnt_d;
         dm_gnt_q <= dm_gnt_d;
         req_q <= req_d;
         we_q <= we_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         tout_q <= tout_d;
      end
   end
   assign if_ack_o = state_q == RESP && !dm_gnt_q;
   assign dm_ack_o = state_q == RESP && dm_gnt_q;
   assign mem_req_o = req_q;
   assign mem_we_o = we_q;
   assign mem_addr_o = addr_q;
   assign mem_wdata_o = wdata_q;
   assign if_rdata_o = if_rdata_q;
   assign dm_rdata_o = dm_rdata_q;
   assign mem_timeout_o = tout_q;
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Arbitrates one shared single-port memory between the MIPS instruction-fetch port (IF) and the data-memory port (DM).
- Sits between the MIPS core and the unified memory model.
- Memory has variable latency and signals completion on mem_ready.
- Arbiter serialises accesses, returns read data, and pulses a per-port ack; the core stalls its stage while req is high and ack is low.

Parameters:
- AW, 32, address width (byte address; passed through unchanged).
- DW, 32, data width.
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF is waiting before IF is forced.
- TIMEOUT, 64, cycles to wait for mem_ready before aborting an access.
- ERR_DATA, 32'hDEADBEEF, rdata returned on timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched word; valid in the if_ack cycle, held afterwards.
- if_ack  out  1  one-cycle completion pulse.
- dm_req  in  1  data request; held with dm_we, dm_addr, dm_wdata until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data; valid in the dm_ack cycle, held afterwards.
- dm_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  memory access strobe; held until mem_ready.
- mem_we  out  1  write enable to memory.
- mem_addr  out  AW  registered address.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  memory read data; valid when mem_ready = 1.
- mem_ready  in  1  access complete; sampled only while mem_req = 1.
- mem_timeout  out  1  one-cycle pulse when an access aborts.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - All outputs 0: mem_*, if_rdata, dm_rdata, both acks, mem_timeout.
  - State = IDLE; streak counter = 0; timeout counter = 0.
  - Reset mid-access drops mem_req immediately and issues no ack.
- IDLE:
  - Samples if_req and dm_req.
  - Grant rule: DM wins if dm_req && !(if_req && streak == MAX_DM_STREAK); otherwise IF wins if if_req.
  - On grant, register the winner's addr, we, and wdata into mem_*. For IF, mem_we = 0 and mem_wdata = 0.
  - Set mem_req = 1 and go to BUSY. The memory sees the request 1 cycle after the sampling edge.
- Streak counter:
  - Increments (saturating at MAX_DM_STREAK) on a DM grant while if_req = 1.
  - Clears on any IF grant, and on a DM grant with if_req = 0.
- BUSY:
  - mem_req, mem_addr, mem_we, and mem_wdata are held stable.
  - The timeout counter increments each cycle.
  - On mem_ready = 1:
    - Capture mem_rdata into the granted port's rdata (stores capture nothing; rdata is kept).
    - Drop mem_req and mem_we; go to RESP.
  - If the counter reaches TIMEOUT-1 without mem_ready:
    - Load ERR_DATA into the granted port's rdata (loads and fetches only).
    - Drop mem_req; pulse mem_timeout for 1 cycle; go to RESP.
- RESP:
  - Granted port's ack = 1 for exactly 1 cycle; timeout counter clears; go to IDLE.
  - The requester deasserts req, or presents a new request, by the edge ending the ack cycle.
  - No sampling occurs in RESP, so a held req is never double-served.
- Latency:
  - Minimum from req sampled to ack = 3 cycles (IDLE → BUSY with mem_ready = 1 in the first BUSY cycle → RESP).
  - Back-to-back turnaround between accesses = 1 IDLE cycle.
- Simultaneous requests in IDLE: DM served first unless the streak limit is reached. IF then waits for at most MAX_DM_STREAK DM accesses.
- Request changes:
  - A req deasserted while BUSY has no effect; the access completes and ack still pulses.
  - Address or data changes while BUSY are ignored because the values are registered.
- Invariants:
  - Never both acks in the same cycle.
  - Never mem_req in IDLE or RESP.

Test Plan:
- Single IF fetch: if_req = 1, if_addr = 0x0000_0040, memory returns 0x2008_0005 with mem_ready on the 2nd BUSY cycle → mem_addr = 0x40, mem_we = 0; if_ack 1 cycle later; if_rdata = 0x2008_0005.
- Store then load: dm store of 0x1234_5678 to 0x100, then a load from 0x100 → store: mem_we = 1, dm_ack, dm_rdata unchanged; load: dm_rdata = 0x1234_5678.
- Simultaneous requests, if_req and dm_req both held, streak 0 → DM granted first, IF second; 1 IDLE cycle between accesses.
- Starvation, MAX_DM_STREAK = 4, dm_req re-asserted continuously and if_req held → exactly 4 dm_acks, then if_ack, then the streak clears.
- Timeout, TIMEOUT = 64, mem_ready held 0 on an IF fetch → after 64 BUSY cycles mem_timeout pulses; if_rdata = 0xDEADBEEF; if_ack pulses; arbiter accepts the next request.
- Reset mid-access: rst_n = 0 during BUSY → mem_req = 0 immediately, no ack; after release, a new request completes normally.
